// File: rtl/sram_stall_pkg.sv
// Shared types and defaults for the 32-bit-over-16-bit SRAM stall controller.
package sram_stall_pkg;
  localparam int unsigned SRAM_DW         = 16;
  localparam int unsigned SRAM_AW_DEF     = 18;
  localparam int unsigned BASE_ADDR_DEF   = 1024;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned TIMER_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // The timer counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [TIMER_W-1:0] timer_load(input int unsigned wait_cycles);
    return TIMER_W'(wait_cycles - 1);
  endfunction
endpackage

// File: rtl/sram_wait_timer.sv
// Phase timer: down-counter reloaded on each phase entry; o_done marks the last cycle of a phase.
module sram_wait_timer
  import sram_stall_pkg::*;
#(
  parameter logic [TIMER_W-1:0] LOAD_VAL = 4'd1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_done
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/sram_stall_ctrl.sv
// MEM-stage SRAM sequencer: each 32-bit access becomes a low then a high 16-bit access.
// Optional macro SRAM_STALL_CNT_EN adds a free-running stall_count output.
module sram_stall_ctrl
  import sram_stall_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
  parameter int unsigned SRAM_AW     = SRAM_AW_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [31:0]         address,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  output logic                ready,
  inout  wire  [SRAM_DW-1:0]  sram_dq,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic                sram_we_n,
  output logic                sram_oe_n,
  output logic                sram_ce_n,
  output logic                sram_ub_n,
  output logic                sram_lb_n
`ifdef SRAM_STALL_CNT_EN
  ,
  output logic [31:0]         stall_count
`endif
);

  // state | meaning
  // IDLE  | no access; strobes inactive, waiting for rd_en/wr_en
  // LO    | low half-word access at {w,0}, held WAIT_CYCLES cycles
  // HI    | high half-word access at {w,1}, held WAIT_CYCLES cycles
  // DONE  | access complete; ready high, pipeline advances on this edge

  state_t r_state, w_state_nxt;

  logic                 w_req;
  logic                 w_timer_load;
  logic                 w_timer_done;
  logic [31:0]          w_offset;
  logic [SRAM_AW-2:0]   w_word;
  logic                 w_unused;
  logic                 w_active;
  logic                 w_drive;
  logic [SRAM_DW-1:0]   w_dout;

  logic                 r_is_wr;
  logic [SRAM_AW-2:0]   r_word;
  logic [31:0]          r_wdata;
  logic [31:0]          r_read_data;

  assign w_req    = rd_en | wr_en;
  assign w_offset = address - BASE_ADDR;
  assign w_word   = w_offset[SRAM_AW:2];
  assign w_unused = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};

  sram_wait_timer #(
    .LOAD_VAL (timer_load(WAIT_CYCLES))
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_timer_load),
    .o_done (w_timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_nxt  = LO;
          w_timer_load = 1'b1;
        end
      end
      LO: begin
        if (w_timer_done) begin
          w_state_nxt  = HI;
          w_timer_load = 1'b1;
        end
      end
      HI: begin
        if (w_timer_done) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request is captured at start so a dropped request still completes consistently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_wr <= 1'b0;
      r_word  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && w_req) begin
      r_is_wr <= wr_en;
      r_word  <= w_word;
      r_wdata <= write_data;
    end
  end

  assign w_active = (r_state == LO) || (r_state == HI);

  always_comb begin
    sram_ce_n = 1'b1;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_ub_n = 1'b1;
    sram_lb_n = 1'b1;
    sram_addr = '0;
    w_drive   = 1'b0;
    w_dout    = '0;
    if (w_active) begin
      sram_ce_n = 1'b0;
      sram_ub_n = 1'b0;
      sram_lb_n = 1'b0;
      sram_addr = {r_word, (r_state == HI)};
      if (r_is_wr) begin
        sram_we_n = 1'b0;
        w_drive   = 1'b1;
        w_dout    = (r_state == HI) ? r_wdata[31:16] : r_wdata[15:0];
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  assign sram_dq = w_drive ? w_dout : {SRAM_DW{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_data <= '0;
    end else if (!r_is_wr && w_timer_done) begin
      if (r_state == LO) begin
        r_read_data[15:0] <= sram_dq;
      end else if (r_state == HI) begin
        r_read_data[31:16] <= sram_dq;
      end
    end
  end

  assign read_data = r_read_data;
  assign ready     = ~w_req | (r_state == DONE);

`ifdef SRAM_STALL_CNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (!ready) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_sram_stall_ctrl.sv
// Bench for sram_stall_ctrl: vector table, hand-written corner sequences, randomized accesses vs. a word-level memory model.
module tb_sram_stall_ctrl;
  localparam int unsigned BASE = 1024;
`ifdef SRAM_STALL_CNT_EN
  localparam int W = 1;
`else
  localparam int W = 2;
`endif
  localparam logic [4:0] STB_IDLE  = 5'b11111;
  localparam logic [4:0] STB_WRITE = 5'b00100;
  localparam logic [4:0] STB_READ  = 5'b01000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  sram_stall_ctrl #(.BASE_ADDR(BASE), .SRAM_AW(18), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_dq    (sram_dq),
    .sram_addr  (sram_addr),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .sram_ce_n  (sram_ce_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
`ifdef SRAM_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  // Asynchronous 16-bit SRAM model.
  logic [15:0] mem [0:262143];
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq;
  end
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

  int errors = 0;
  int checks = 0;
  logic [31:0] ref_mem [int];
  int          written_q [$];
  logic [31:0] exp_rd_last = 32'h0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] exp_lo;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n};
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'(((addr - BASE) >> 2) % 131072);
  endfunction

  // One complete access with per-cycle checks; the request stays up through DONE.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [17:0] exp_lo,
                            input logic [31:0] exp_rd, input string tag);
    int phase;
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = addr; write_data = wdata;
    for (int k = 0; k <= 2*W+1; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      phase = (k == 0) ? 0 : (k <= W) ? 1 : (k <= 2*W) ? 2 : 3;
      chk($sformatf("%s ready k%0d", tag, k), {31'd0, ready}, {31'd0, phase == 3});
      if (phase == 1 || phase == 2) begin
        chk($sformatf("%s strobes k%0d", tag, k), {27'd0, strobes()},
            {27'd0, wr ? STB_WRITE : STB_READ});
        chk($sformatf("%s addr k%0d", tag, k), {14'd0, sram_addr},
            {14'd0, exp_lo + 18'(phase - 1)});
        if (wr)
          chk($sformatf("%s dq k%0d", tag, k), {16'd0, sram_dq},
              {16'd0, (phase == 2) ? wdata[31:16] : wdata[15:0]});
      end else begin
        chk($sformatf("%s strobes k%0d", tag, k), {27'd0, strobes()}, {27'd0, STB_IDLE});
        chk($sformatf("%s addr k%0d", tag, k), {14'd0, sram_addr}, 32'd0);
      end
      if (phase == 3) chk($sformatf("%s read_data", tag), read_data, exp_rd);
    end
    if (wr) begin
      if (!ref_mem.exists(word_of(addr))) written_q.push_back(word_of(addr));
      ref_mem[word_of(addr)] = wdata;
    end
    exp_rd_last = exp_rd;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, er;
    int          idx, op;
    logic [31:0] s0;

    vecs[0] = '{1'b0, 1'b1, 32'd1024,   32'hDEADBEEF, 18'h00000, 32'h00000000, "wr_1024"};
    vecs[1] = '{1'b1, 1'b0, 32'd1024,   32'h00000000, 18'h00000, 32'hDEADBEEF, "rd_1024"};
    vecs[2] = '{1'b0, 1'b1, 32'd1032,   32'h12345678, 18'h00004, 32'hDEADBEEF, "wr_1032"};
    vecs[3] = '{1'b1, 1'b0, 32'd1035,   32'h00000000, 18'h00004, 32'h12345678, "rd_1035"};
    vecs[4] = '{1'b0, 1'b1, 32'd525308, 32'hCAFEF00D, 18'h3FFFE, 32'h12345678, "wr_top"};
    vecs[5] = '{1'b1, 1'b0, 32'd525308, 32'h00000000, 18'h3FFFE, 32'hCAFEF00D, "rd_top"};
    vecs[6] = '{1'b1, 1'b1, 32'd1032,   32'h0A0B0C0D, 18'h00004, 32'hCAFEF00D, "both_1032"};
    vecs[7] = '{1'b1, 1'b0, 32'd1032,   32'h00000000, 18'h00004, 32'h0A0B0C0D, "rd_both"};

    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset ready", {31'd0, ready}, 32'd1);
    chk("reset strobes", {27'd0, strobes()}, {27'd0, STB_IDLE});
    chk("reset addr", {14'd0, sram_addr}, 32'd0);
    chk("reset read_data", read_data, 32'd0);
`ifdef SRAM_STALL_CNT_EN
    chk("reset stall_count", stall_count, 32'd0);
`endif
    rd_en = 1'b1;
    #1;
    chk("reset ready with req", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rd_en = 1'b0; rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_lo, vecs[i].exp_rd, vecs[i].name);
    idle_cycle();

    // Reset asserted during the HI phase of a read.
    @(negedge clk);
    rd_en = 1'b1; wr_en = 1'b0; address = 32'd1024;
    repeat (W+1) @(negedge clk);
    #1;
    chk("rst_mid in HI", {14'd0, sram_addr}, 32'd1);
    chk("rst_mid partial lo", read_data, {exp_rd_last[31:16], 16'hBEEF});
    rst = 1'b1;
    #1;
    chk("rst_mid strobes", {27'd0, strobes()}, {27'd0, STB_IDLE});
    chk("rst_mid addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_mid read_data", read_data, 32'd0);
    chk("rst_mid ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid after strobes", {27'd0, strobes()}, {27'd0, STB_IDLE});
    run_access(1'b1, 1'b0, 32'd1024, 32'd0, 18'h0, 32'hDEADBEEF, "rst_rd");

    // Write request dropped after the access has started.
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1040; write_data = 32'h55AA33CC;
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    chk("drop ready", {31'd0, ready}, 32'd1);
    chk("drop lo strobes", {27'd0, strobes()}, {27'd0, STB_WRITE});
    repeat (W) @(negedge clk);
    #1;
    chk("drop hi strobes", {27'd0, strobes()}, {27'd0, STB_WRITE});
    chk("drop hi addr", {14'd0, sram_addr}, 32'd9);
    chk("drop hi dq", {16'd0, sram_dq}, 32'h55AA);
    repeat (W) @(negedge clk);
    #1;
    chk("drop done strobes", {27'd0, strobes()}, {27'd0, STB_IDLE});
    @(negedge clk);
    #1;
    chk("drop idle strobes", {27'd0, strobes()}, {27'd0, STB_IDLE});
    if (!ref_mem.exists(4)) written_q.push_back(4);
    ref_mem[4] = 32'h55AA33CC;
    run_access(1'b1, 1'b0, 32'd1040, 32'd0, 18'd8, 32'h55AA33CC, "drop_rb");
    idle_cycle();

`ifdef SRAM_STALL_CNT_EN
    s0 = stall_count;
    run_access(1'b0, 1'b1, 32'd1100, 32'h01020304, 18'(word_of(32'd1100) * 2), exp_rd_last, "cnt_wr");
    idle_cycle();
    run_access(1'b1, 1'b0, 32'd1100, 32'd0, 18'(word_of(32'd1100) * 2), 32'h01020304, "cnt_rd");
    idle_cycle();
    chk("stall_count delta", stall_count - s0, 32'(2 * (1 + 2*W)));
`else
    s0 = 32'd0;
`endif

    // Randomized accesses checked against the word-level memory model.
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      if (op == 2 && written_q.size() > 0) begin
        idx = written_q[$urandom_range(0, written_q.size() - 1)];
        a   = BASE + 32'(idx) * 4 + $urandom_range(0, 3);
        run_access(1'b1, 1'b0, a, 32'd0, 18'(idx * 2), ref_mem[idx], $sformatf("rnd%0d_rd", n));
      end else begin
        idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 131071) : $urandom_range(0, 63);
        a   = BASE + 32'(idx) * 4 + $urandom_range(0, 3);
        d   = $urandom;
        er  = exp_rd_last;
        run_access(op == 3, 1'b1, a, d, 18'(idx * 2), er, $sformatf("rnd%0d_wr", n));
      end
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
